// File: rtl/method_divider.sv
// method_divider: sequential unsigned restoring divider.
// One trial subtraction per clock; an N-bit quotient and remainder are ready
// after N iterations. A start/busy/done handshake lets the ALU select logic
// launch an operation and wait for the result.
// Optional macro SIGNED_DIV_EN: two's-complement operands. Magnitudes are
// divided by the unsigned core and the signs are restored at the end
// (truncation toward zero). Without the macro no sign logic exists.
module method_divider #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  rem;      // partial remainder
    logic [N-1:0]  dvd;      // dividend, shifted out as quotient bits shift in
    logic [N-1:0]  dvs;      // latched divisor (magnitude in signed mode)
    logic [CW-1:0] cnt;      // completed iterations

    logic          accept;
    logic          last;
    logic          b_zero;
    logic [N-1:0]  a_mag;
    logic [N-1:0]  b_mag;
    logic [N:0]    rem_sh;
    logic          ge;
    logic [N-1:0]  trial;
    logic [N-1:0]  rem_nxt;
    logic [N-1:0]  dvd_nxt;
    logic [N-1:0]  q_fin;
    logic [N-1:0]  r_fin;

    // A new operation is taken from IDLE, or straight out of FIN (back-to-back).
    assign b_zero = (B == '0);
    assign accept = start && (state == IDLE || state == FIN);
    assign last   = (cnt == CW'(N - 1));

    // One restoring step: shift {rem, dvd} left, try rem - divisor.
    // The shifted remainder is N+1 bits, so the non-negative test is done as a
    // full-width compare; when it passes the difference always fits in N bits.
    assign rem_sh  = {rem, dvd[N-1]};
    assign ge      = (rem_sh >= {1'b0, dvs});
    assign trial   = rem_sh[N-1:0] - dvs;
    assign rem_nxt = ge ? trial : rem_sh[N-1:0];
    assign dvd_nxt = {dvd[N-2:0], ge};

`ifdef SIGNED_DIV_EN
    logic neg_q;
    logic neg_r;

    function automatic logic [N-1:0] negate(input logic [N-1:0] x);
        return ~x + N'(1);
    endfunction

    // Most-negative has magnitude 2^(N-1), which still fits as an unsigned N-bit value.
    assign a_mag = A[N-1] ? negate(A) : A;
    assign b_mag = B[N-1] ? negate(B) : B;
    assign q_fin = neg_q ? negate(dvd_nxt) : dvd_nxt;
    assign r_fin = neg_r ? negate(rem_nxt) : rem_nxt;

    // Remember the result signs at the start edge; operands may change afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= A[N-1] ^ B[N-1];
            neg_r <= A[N-1];
        end
    end
`else
    assign a_mag = A;
    assign b_mag = B;
    assign q_fin = dvd_nxt;
    assign r_fin = rem_nxt;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = b_zero ? FIN : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = b_zero ? FIN : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Iteration datapath; Q/R/div_zero change only when a result is final.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            Q        <= '0;
            R        <= '0;
            div_zero <= 1'b0;
        end else if (accept) begin
            rem      <= '0;
            cnt      <= '0;
            dvd      <= a_mag;
            dvs      <= b_mag;
            div_zero <= b_zero;
            if (b_zero) begin
                Q <= '1;
                R <= A;
            end
        end else if (state == RUN) begin
            rem <= rem_nxt;
            dvd <= dvd_nxt;
            cnt <= cnt + CW'(1);
            if (last) begin
                Q <= q_fin;
                R <= r_fin;
            end
        end
    end

endmodule

// File: tb/tb_method_divider.sv
// tb_method_divider: random and directed stimulus for method_divider, checked
// every cycle against a behavioural model (plain division plus a countdown to
// completion) and against hand-computed literal results.
module tb_method_divider;
    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] Q;
    logic [N-1:0] R;
    logic         busy;
    logic         done;
    logic         div_zero;

    int pass_cnt  = 0;
    int total_cnt = 0;

    method_divider #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (A),
        .B        (B),
        .Q        (Q),
        .R        (R),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference arithmetic straight from the divider's definition.
    function automatic logic [N-1:0] ref_q(input logic [N-1:0] a, input logic [N-1:0] b);
        int sa;
        int sb;
        if (b == '0) return '1;
`ifdef SIGNED_DIV_EN
        sa = $signed(a);
        sb = $signed(b);
        return N'(sa / sb);
`else
        sa = int'(a);
        sb = int'(b);
        return N'(sa / sb);
`endif
    endfunction

    function automatic logic [N-1:0] ref_r(input logic [N-1:0] a, input logic [N-1:0] b);
        int sa;
        int sb;
        if (b == '0) return a;
`ifdef SIGNED_DIV_EN
        sa = $signed(a);
        sb = $signed(b);
        return N'(sa % sb);
`else
        sa = int'(a);
        sb = int'(b);
        return N'(sa % sb);
`endif
    endfunction

    // Model: m_cyc counts edges left until the result shows (0 = done cycle, -1 = idle).
    int           m_cyc;
    logic [N-1:0] m_q, m_r, pend_q, pend_r;
    logic         m_dz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc <= -1;
            m_q   <= '0;
            m_r   <= '0;
            m_dz  <= 1'b0;
        end else if (m_cyc > 0) begin
            m_cyc <= m_cyc - 1;
            if (m_cyc == 1) begin
                m_q <= pend_q;
                m_r <= pend_r;
            end
        end else if (start) begin
            m_dz <= (B == '0);
            if (B == '0) begin
                m_cyc <= 0;
                m_q   <= ref_q(A, B);
                m_r   <= ref_r(A, B);
            end else begin
                m_cyc  <= N;
                pend_q <= ref_q(A, B);
                pend_r <= ref_r(A, B);
            end
        end else begin
            m_cyc <= -1;
        end
    end

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        check("busy", busy, m_cyc > 0);
        check("done", done, m_cyc == 0);
        check("div_zero", div_zero, m_dz);
        check("Q", Q, m_q);
        check("R", R, m_r);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Launch one operation, wait (bounded) for done, check literal results.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] eq, input logic [N-1:0] er,
                          input logic edz, input int elat);
        int edges;
        start = 1'b1; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; A = N'($urandom); B = N'($urandom);
        edges = 1;
        while (!done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check("op_latency", edges, elat);
        check("op_Q", Q, eq);
        check("op_R", R, er);
        check("op_div_zero", div_zero, edz);
    endtask

    initial begin
        int edges;
        int seen_done;
        rst_n = 1'b1; start = 1'b0; A = '0; B = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_Q", Q, 0);
        check("rst_R", R, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div_zero", div_zero, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

`ifdef SIGNED_DIV_EN
        run_op(4'b1001, 4'd2,    4'b1101, 4'b1111, 1'b0, 5);  // -7 / 2
        idle(1);
        run_op(4'd7,    4'b1110, 4'b1101, 4'b0001, 1'b0, 5);  // 7 / -2
        idle(1);
        run_op(4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 5);  // -8 / -1
        idle(1);
        run_op(4'b1001, 4'd0,    4'b1111, 4'b1001, 1'b1, 1);  // -7 / 0
        idle(1);
        run_op(4'd6,    4'd2,    4'd3,    4'd0,    1'b0, 5);
        idle(1);
`else
        run_op(4'd13, 4'd3, 4'd4,  4'd1, 1'b0, 5);
        idle(1);
        run_op(4'd9,  4'd0, 4'd15, 4'd9, 1'b1, 1);
        idle(1);
        run_op(4'd6,  4'd2, 4'd3,  4'd0, 1'b0, 5);
        idle(1);
        run_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5);
        idle(1);
        run_op(4'd2,  4'd7, 4'd0,  4'd2, 1'b0, 5);
        idle(1);
        run_op(4'd0,  4'd5, 4'd0,  4'd0, 1'b0, 5);
        idle(1);

        // start held through RUN with different operands: must be ignored.
        start = 1'b1; A = 4'd13; B = 4'd3;
        @(posedge clk); #1;
        edges = 1;
        A = 4'd1; B = 4'd1;
        repeat (3) begin
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        while (!done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check("held_latency", edges, 5);
        check("held_Q", Q, 4);
        check("held_R", R, 1);
        // Back-to-back launch from the done cycle.
        run_op(4'd8, 4'd2, 4'd4, 4'd0, 1'b0, 5);
        idle(1);
`endif

        // Asynchronous reset in the middle of an operation.
        start = 1'b1; A = 4'd13; B = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_Q", Q, 0);
        check("midrst_R", R, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen_done = 0;
        repeat (N + 2) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        check("midrst_no_done", seen_done, 0);
`ifdef SIGNED_DIV_EN
        run_op(4'd10, 4'd4, 4'b1111, 4'b1110, 1'b0, 5);  // -6 / 4
`else
        run_op(4'd10, 4'd4, 4'd2, 4'd2, 1'b0, 5);
`endif
        idle(1);

        // Random traffic, including back-to-back starts, B == 0 and stray resets.
        repeat (2000) begin
            start = ($urandom_range(0, 2) == 0);
            A = N'($urandom);
            B = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        idle(N + 3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
